// File: rtl/pc_stall_unit.sv
// PC register with a configurable load-wait hold, external freeze and
// a redirect path that overrides both.
module pc_stall_unit #(
  parameter int              XLEN              = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR      = '0,
  parameter int              LOAD_STALL_CYCLES = 1,
  parameter bit              FULL_OPCODE_MATCH = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic [XLEN-1:0] i_pc_next,
  input  logic [31:0]     i_inst,
  input  logic            i_ext_stall,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  output logic [XLEN-1:0] o_pc,
  output logic            o_stall,
  output logic            o_advance,
  output logic            o_misaligned
);

  localparam int CW =
    (LOAD_STALL_CYCLES < 2) ? 1 : $clog2(LOAD_STALL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LOAD_STALL_CYCLES);
  localparam bit HOLD_EN = (LOAD_STALL_CYCLES > 0);

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            load;
  logic            unused_inst;

  // Legacy mode ignores the two low opcode bits.
  assign load = FULL_OPCODE_MATCH ? (i_inst[6:0] == 7'b0000011)
                                  : (i_inst[6:2] == 5'b00000);
  assign unused_inst = ^i_inst[31:7];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_d      = pc_q;
    o_advance = 1'b0;
    if (i_redirect) begin
      pc_d      = i_redirect_pc;
      state_d   = ST_RUN;
      cnt_d     = '0;
      o_advance = 1'b1;
    end else if (i_ext_stall) begin
      pc_d      = pc_q;
    end else if (state_q == ST_RUN) begin
      if (load && HOLD_EN) begin
        state_d = ST_WAIT;
        cnt_d   = CNT_INIT;
      end else begin
        pc_d      = i_pc_next;
        o_advance = 1'b1;
      end
    end else if (cnt_q > CW'(1)) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      pc_d      = i_pc_next;
      state_d   = ST_RUN;
      cnt_d     = '0;
      o_advance = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign o_pc         = pc_q;
  assign o_stall      = HOLD_EN && (state_q == ST_WAIT);
  assign o_misaligned = |pc_q[1:0];

endmodule

// File: tb/tb_pc_stall_unit.sv
// Directed bench for pc_stall_unit: four parameter sets driven from
// one shared stimulus, each phase checking the instance it targets.
module tb_pc_stall_unit;

  localparam logic [31:0] RV  = 32'h0000_0100;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] LW  = 32'h0000_2083;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc_next = '0;
  logic [31:0] inst = NOP;
  logic        ext_stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] a_pc, b_pc, c_pc, d_pc;
  logic a_st, b_st, c_st, d_st;
  logic a_adv, b_adv, c_adv, d_adv;
  logic a_mis, b_mis, c_mis, d_mis;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pc_stall_unit #(.RESET_VECTOR(RV), .LOAD_STALL_CYCLES(1),
                  .FULL_OPCODE_MATCH(1'b1)) u_a (
    .i_clk(clk), .i_reset(rst), .i_pc_next(pc_next), .i_inst(inst),
    .i_ext_stall(ext_stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_pc(a_pc), .o_stall(a_st),
    .o_advance(a_adv), .o_misaligned(a_mis));

  pc_stall_unit #(.RESET_VECTOR(RV), .LOAD_STALL_CYCLES(3),
                  .FULL_OPCODE_MATCH(1'b1)) u_b (
    .i_clk(clk), .i_reset(rst), .i_pc_next(pc_next), .i_inst(inst),
    .i_ext_stall(ext_stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_pc(b_pc), .o_stall(b_st),
    .o_advance(b_adv), .o_misaligned(b_mis));

  pc_stall_unit #(.RESET_VECTOR(RV), .LOAD_STALL_CYCLES(1),
                  .FULL_OPCODE_MATCH(1'b0)) u_c (
    .i_clk(clk), .i_reset(rst), .i_pc_next(pc_next), .i_inst(inst),
    .i_ext_stall(ext_stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_pc(c_pc), .o_stall(c_st),
    .o_advance(c_adv), .o_misaligned(c_mis));

  pc_stall_unit #(.RESET_VECTOR(RV), .LOAD_STALL_CYCLES(0),
                  .FULL_OPCODE_MATCH(1'b1)) u_d (
    .i_clk(clk), .i_reset(rst), .i_pc_next(pc_next), .i_inst(inst),
    .i_ext_stall(ext_stall), .i_redirect(redirect),
    .i_redirect_pc(redirect_pc), .o_pc(d_pc), .o_stall(d_st),
    .o_advance(d_adv), .o_misaligned(d_mis));

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jump(input logic [31:0] addr);
    redirect    = 1'b1;
    redirect_pc = addr;
    step();
    redirect    = 1'b0;
  endtask

  initial begin
    // reset asserted mid-cycle takes effect without a clock edge
    #13;
    rst = 1'b0;
    #1;
    chk("rst_pc", a_pc, RV);
    chk("rst_stall", {31'b0, a_st}, 32'd0);
    step();
    rst     = 1'b1;
    inst    = NOP;
    pc_next = 32'h104;
    step();
    chk("first_pc", a_pc, 32'h104);

    // one-cycle load hold
    jump(32'h8);
    inst    = LW;
    pc_next = 32'hC;
    #1;
    chk("lw1_adv0", {31'b0, a_adv}, 32'd0);
    chk("l0_adv0", {31'b0, d_adv}, 32'd1);
    step();
    chk("lw1_pc1", a_pc, 32'h8);
    chk("lw1_st1", {31'b0, a_st}, 32'd1);
    chk("lw1_adv1", {31'b0, a_adv}, 32'd1);
    chk("l0_pc1", d_pc, 32'hC);
    chk("l0_st1", {31'b0, d_st}, 32'd0);
    step();
    chk("lw1_pc2", a_pc, 32'hC);
    chk("lw1_st2", {31'b0, a_st}, 32'd0);
    chk("lw3_pc2", b_pc, 32'h8);

    // three-cycle load hold
    jump(32'h20);
    inst    = LW;
    pc_next = 32'h24;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) begin
        chk($sformatf("lw3_pc_e%0d", k), b_pc, 32'h20);
        chk($sformatf("lw3_st_e%0d", k), {31'b0, b_st}, 32'd1);
      end else begin
        chk("lw3_pc_e4", b_pc, 32'h24);
        chk("lw3_st_e4", {31'b0, b_st}, 32'd0);
      end
    end
    chk("l0_st_const", {31'b0, d_st}, 32'd0);

    // freeze while the counter sits at one
    jump(32'h30);
    inst    = LW;
    pc_next = 32'h34;
    step();
    ext_stall = 1'b1;
    #1;
    chk("frz_adv", {31'b0, a_adv}, 32'd0);
    step();
    chk("frz_pc1", a_pc, 32'h30);
    chk("frz_st1", {31'b0, a_st}, 32'd1);
    step();
    chk("frz_pc2", a_pc, 32'h30);
    ext_stall = 1'b0;
    #1;
    chk("frz_adv_rel", {31'b0, a_adv}, 32'd1);
    step();
    chk("frz_pc3", a_pc, 32'h34);
    chk("frz_st3", {31'b0, a_st}, 32'd0);

    // redirect beats freeze and an active wait
    jump(32'h50);
    inst    = LW;
    pc_next = 32'h54;
    step();
    step();
    chk("rd_pre_pc", b_pc, 32'h50);
    chk("rd_pre_st", {31'b0, b_st}, 32'd1);
    ext_stall   = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    #1;
    chk("rd_adv", {31'b0, b_adv}, 32'd1);
    step();
    redirect  = 1'b0;
    ext_stall = 1'b0;
    chk("rd_pc", b_pc, 32'h40);
    chk("rd_st", {31'b0, b_st}, 32'd0);

    // opcode match modes and misalignment
    jump(32'h60);
    inst    = 32'h0000_0000;
    pc_next = 32'h64;
    step();
    chk("full_pc", a_pc, 32'h64);
    chk("legacy_pc", c_pc, 32'h60);
    chk("legacy_st", {31'b0, c_st}, 32'd1);
    chk("mis0", {31'b0, a_mis}, 32'd0);

    // reset while waiting
    #2;
    rst = 1'b0;
    #1;
    chk("rst_wait_pc", c_pc, RV);
    chk("rst_wait_st", {31'b0, c_st}, 32'd0);
    step();
    rst = 1'b1;
    inst = NOP;
    jump(32'h2);
    #1;
    chk("mis1", {31'b0, a_mis}, 32'd1);
    chk("mis_pc", a_pc, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/pc_stall_unit.md
# pc_stall_unit

Parametrised program-counter register for the single-cycle RV32I core with a multi-cycle load-wait state machine, an external freeze input and a priority redirect path. It replaces the fixed one-cycle load hold with a configurable hold count. It sits between the next-PC mux (PC+4 / branch target) and the instruction memory address. It tells the rest of the datapath when the instruction at `o_pc` completes.

## Interface
- `XLEN`, 32: PC width in bits.
- `RESET_VECTOR`, 32'h0000_0000: value loaded into `o_pc` on reset.
- `LOAD_STALL_CYCLES`, 1: extra cycles a load holds the PC. Legal range 0..15; 0 disables the load hold.
- `FULL_OPCODE_MATCH`, 1: load-detect mode.
  - 1: load when `i_inst[6:0] == 7'b0000011`.
  - 0: legacy match on `i_inst[6:2] == 5'b00000`.
- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  asynchronous, active-low reset.
- `i_pc_next`  in  XLEN  next sequential/branch PC from the next-PC mux.
- `i_inst`  in  32  instruction currently fetched at `o_pc`.
- `i_ext_stall`  in  1  freeze request, e.g. memory not ready.
- `i_redirect`  in  1  redirect strobe (trap/exception vector).
- `i_redirect_pc`  in  XLEN  redirect target.
- `o_pc`  out  XLEN  current PC, registered.
- `o_stall`  out  1  registered; 1 while in WAIT state.
- `o_advance`  out  1  combinational; 1 in the cycle the PC will update, i.e. the instruction at `o_pc` commits (drives regfile/LSU write enables).
- `o_misaligned`  out  1  combinational; `|o_pc[1:0]`.

## Operation
- **State:**
  - `r_state` ∈ {RUN, WAIT}.
  - Down-counter `r_cnt`, width `max(1, $clog2(LOAD_STALL_CYCLES+1))`.
- `w_load` = opcode match per `FULL_OPCODE_MATCH`.
- **Priority per cycle, highest first:**
  1. `i_redirect`: `o_pc <= i_redirect_pc`, state RUN, `r_cnt <= 0`, `o_advance = 1`. Overrides `i_ext_stall` and any load wait.
  2. `i_ext_stall`: `o_pc`, state and `r_cnt` all hold; `o_advance = 0`.
  3. RUN, `w_load = 1`, `LOAD_STALL_CYCLES > 0`: hold `o_pc`, go to WAIT, `r_cnt <= LOAD_STALL_CYCLES`, `o_advance = 0`.
  4. RUN otherwise: `o_pc <= i_pc_next`, `o_advance = 1`.
  5. WAIT, `r_cnt > 1`: hold `o_pc`, `r_cnt <= r_cnt - 1`, `o_advance = 0`.
  6. WAIT, `r_cnt == 1`: `o_pc <= i_pc_next`, state RUN, `r_cnt <= 0`, `o_advance = 1`.
- **Load hold rules:**
  - `w_load` is evaluated only in RUN; `i_inst` content during WAIT is ignored.
  - Back-to-back loads: the second load is detected in the RUN cycle after the first commits and waits its own full count.
- `o_pc` is written exactly as supplied. There is no forced alignment; `o_misaligned` flags bits [1:0] for the trap logic.
- Arithmetic: `r_cnt` never underflows; the decrement happens only when `r_cnt > 1` in WAIT.

## Timing
- **Reset (async, `i_reset` low):**
  - `o_pc = RESET_VECTOR`, state RUN, `r_cnt = 0`, `o_stall = 0`, effective immediately.
  - First PC update occurs on the first rising edge with `i_reset` high.
- **Non-load instruction:** `o_pc` changes 1 edge after presentation.
- **Load instruction:** occupies `o_pc` for `LOAD_STALL_CYCLES + 1` cycles, not counting `i_ext_stall` cycles.
- **`o_stall`:** rises on the edge entering WAIT and falls on the edge leaving it.
- **`o_advance`:** purely combinational from state, `r_cnt`, `w_load`, `i_ext_stall` and `i_redirect`; no registered latency.
- **Boundary conditions:**
  - `i_ext_stall` asserted in the WAIT cycle with `r_cnt == 1`: stays in WAIT with `r_cnt = 1` until the stall drops.
  - Redirect during WAIT: wait aborted, no residual stall.
  - Reset mid-WAIT: returns to RUN at `RESET_VECTOR`.
  - `LOAD_STALL_CYCLES = 0`: the WAIT state is unreachable and `o_stall` is constantly 0.

## Test plan
- **Reset:** assert `i_reset = 0` mid-cycle with `RESET_VECTOR = 32'h0000_0100` -> `o_pc = 32'h100` immediately, `o_stall = 0`. Release, `i_inst = 32'h0000_0013` (addi), `i_pc_next = 32'h104` -> `o_pc = 32'h104` after 1 edge.
- **Legacy-equivalent load hold:** `LOAD_STALL_CYCLES = 1`, `i_inst = 32'h0000_2083` (lw) at `o_pc = 32'h8`, `i_pc_next = 32'hC`.
  - Cycle 0: `o_advance = 0`.
  - Edge 1: `o_pc = 8`, `o_stall = 1`, `o_advance = 1`.
  - Edge 2: `o_pc = 32'hC`, `o_stall = 0`.
- **Configurable hold:** `LOAD_STALL_CYCLES = 3`, lw at `32'h20` -> `o_pc` stays `32'h20` for 4 cycles and becomes `32'h24` on edge 4. `o_stall` is high for exactly 3 cycles.
- **External freeze:** during WAIT with `r_cnt = 1`, hold `i_ext_stall = 1` for 2 cycles -> `o_pc` unchanged, `o_advance = 0`. After release, `o_pc` advances on the next edge; total load occupancy = 2 + 2 cycles.
- **Redirect priority:** in WAIT with `r_cnt = 2`, pulse `i_redirect = 1`, `i_redirect_pc = 32'h0000_0040`, with `i_ext_stall = 1` simultaneously -> next edge: `o_pc = 32'h40`, `o_stall = 0`, `o_advance` was 1.
- **Opcode modes:** `i_inst[6:0] = 7'b0000000`.
  - With `FULL_OPCODE_MATCH = 1`: no hold, `o_pc` advances.
  - With `FULL_OPCODE_MATCH = 0`: hold occurs.
  - `o_pc = 32'h2` gives `o_misaligned = 1`.
